// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the UART boot-path program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_WRITE,
    ST_DONE
  } state_e;

  localparam logic [31:0] DEFAULT_END_MARKER = 32'h0000_0FFF;

  // Width of a counter that must reach cycles-1.
  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/prog_word_assembler.sv
// Packs UART bytes little-endian into 32-bit words and discards a partial
// word when the byte stream stalls for TIMEOUT_CYC cycles.
module prog_word_assembler
  import prog_loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o,
  output logic        frame_err_o
);

  localparam int TW = timer_width(TIMEOUT_CYC);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [23:0]   lanes_q, lanes_d;
  logic [31:0]   word_q, word_d;
  logic [TW-1:0] timer_q, timer_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    byte_idx_d   = byte_idx_q;
    lanes_d      = lanes_q;
    word_d       = word_q;
    timer_d      = timer_q;
    word_valid_o = 1'b0;
    frame_err_o  = 1'b0;

    if (clear_i) begin
      byte_idx_d = '0;
      lanes_d    = '0;
      timer_d    = '0;
    end else if (enable_i && rx_valid_i) begin
      timer_d = '0;
      case (byte_idx_q)
        2'd0:    lanes_d[7:0]   = rx_byte_i;
        2'd1:    lanes_d[15:8]  = rx_byte_i;
        2'd2:    lanes_d[23:16] = rx_byte_i;
        default: begin
          // Fourth byte goes straight into the word register, not a lane.
          word_d       = {rx_byte_i, lanes_q};
          word_valid_o = 1'b1;
        end
      endcase
      byte_idx_d = byte_idx_q + 2'd1;
    end else if (byte_idx_q != 2'd0) begin
      if (timer_q == TIMER_MAX) begin
        byte_idx_d  = '0;
        timer_d     = '0;
        frame_err_o = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else begin
      timer_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge inputs regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx_q <= '0;
      lanes_q    <= '0;
      word_q     <= '0;
      timer_q    <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      lanes_q    <= lanes_d;
      word_q     <= word_d;
      timer_q    <= timer_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/prog_loader_ctrl.sv
// Boot-path loader: writes UART-received words to imem and holds the core in
// reset until the end marker arrives.
module prog_loader_ctrl
  import prog_loader_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          MEM_WORDS   = 256,
  parameter logic [31:0] END_MARKER  = DEFAULT_END_MARKER,
  parameter int          TIMEOUT_CYC = 20000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              load_en_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_byte_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_rst_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic              frame_err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ovf_q, ovf_d;
  logic              ferr_q, ferr_d;
  logic              load_en_prev_q;

  logic        asm_active;
  logic        word_valid;
  logic [31:0] word;
  logic        asm_frame_err;

  assign asm_active = (state_q == ST_RECV) || (state_q == ST_CHECK) ||
                      (state_q == ST_WRITE);

  prog_word_assembler #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_asm (
    .clk          (wb_clk_i),
    .rst          (wb_rst_i),
    .clear_i      (!asm_active),
    .enable_i     (load_en_i),
    .rx_valid_i   (rx_valid_i),
    .rx_byte_i    (rx_byte_i),
    .word_valid_o (word_valid),
    .word_o       (word),
    .frame_err_o  (asm_frame_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;
    ferr_d  = ferr_q | asm_frame_err;

    case (state_q)
      ST_IDLE: begin
        if (load_en_i) begin
          state_d = ST_RECV;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_RECV: begin
        if (!load_en_i)      state_d = ST_IDLE;
        else if (word_valid) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        // Marker wins over overflow so a full image plus marker ends cleanly.
        if (!load_en_i) begin
          state_d = ST_IDLE;
        end else if (word == END_MARKER) begin
          state_d = ST_DONE;
        end else if (cnt_q == MEM_LIMIT) begin
          state_d = ST_DONE;
          ovf_d   = 1'b1;
        end else begin
          state_d = ST_WRITE;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = word;
        end
      end
      ST_WRITE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = load_en_i ? ST_RECV : ST_IDLE;
      end
      ST_DONE: begin
        if (load_en_i && !load_en_prev_q) begin
          state_d = ST_RECV;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      ovf_q          <= 1'b0;
      ferr_q         <= 1'b0;
      load_en_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      ovf_q          <= ovf_d;
      ferr_q         <= ferr_d;
      load_en_prev_q <= load_en_i;
    end
  end

  assign imem_we_o    = (state_q == ST_WRITE);
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign core_rst_o   = (state_q != ST_DONE);
  assign done_o       = (state_q == ST_DONE);
  assign overflow_o   = ovf_q;
  assign frame_err_o  = ferr_q;
  assign word_cnt_o   = cnt_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Directed bench for prog_loader_ctrl: normal load, back-to-back bytes,
// overflow, timeout, abort/restart and asynchronous reset mid-write.
module tb_prog_loader_ctrl;

  localparam int          ADDR_W      = 2;
  localparam int          MEM_WORDS   = 4;
  localparam int          TIMEOUT_CYC = 1000;
  localparam logic [31:0] MARKER      = 32'h0000_0FFF;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_en;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              overflow;
  logic              frame_err;
  logic [ADDR_W:0]   word_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int byte_cyc = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  prog_loader_ctrl #(
    .ADDR_W      (ADDR_W),
    .MEM_WORDS   (MEM_WORDS),
    .END_MARKER  (MARKER),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .load_en_i    (load_en),
    .rx_valid_i   (rx_valid),
    .rx_byte_i    (rx_byte),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .core_rst_o   (core_rst),
    .done_o       (done),
    .overflow_o   (overflow),
    .frame_err_o  (frame_err),
    .word_cnt_o   (word_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst === 1'b0 && imem_we === 1'b1) begin
      wr_addr.push_back(32'(imem_addr));
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_byte  = b;
    byte_cyc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic restart();
    load_en = 1'b0;
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    clear_log();
  endtask

  initial begin
    int b2b_cyc[2];
    logic [31:0] b2b_words[2];
    logic [31:0] w;
    bit seen_we;

    rst      = 1'b1;
    load_en  = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_flags", {30'd0, overflow, frame_err}, 32'd0);
    check("rst_cnt", 32'(word_cnt), 32'd0);

    // Normal 3-word load, bytes spaced 400 cycles.
    rst = 1'b0;
    @(negedge clk);
    load_en = 1'b1;
    repeat (2) @(negedge clk);
    clear_log();
    send_word(32'h0000_0013, 399);
    send_word(32'h0010_0193, 399);
    send_word(32'h0000_0063, 399);
    send_word(MARKER, 399);
    check("load3_nwrites", 32'(wr_addr.size()), 32'd3);
    if (wr_addr.size() == 3) begin
      check("load3_a0", wr_addr[0], 32'd0);
      check("load3_d0", wr_data[0], 32'h0000_0013);
      check("load3_a1", wr_addr[1], 32'd1);
      check("load3_d1", wr_data[1], 32'h0010_0193);
      check("load3_a2", wr_addr[2], 32'd2);
      check("load3_d2", wr_data[2], 32'h0000_0063);
    end
    check("load3_done", 32'(done), 32'd1);
    check("load3_core_rst", 32'(core_rst), 32'd0);
    check("load3_cnt", 32'(word_cnt), 32'd3);
    check("load3_flags", {30'd0, overflow, frame_err}, 32'd0);

    // Dropping load_en in DONE keeps the core running.
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    check("done_hold_done", 32'(done), 32'd1);
    check("done_hold_core_rst", 32'(core_rst), 32'd0);
    load_en = 1'b1;
    @(negedge clk);
    check("restart_core_rst", 32'(core_rst), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_cnt", 32'(word_cnt), 32'd0);
    clear_log();

    // Back-to-back bytes: two words on eight consecutive cycles.
    b2b_words[0] = 32'hDEAD_BEEF;
    b2b_words[1] = 32'h0123_4567;
    for (int i = 0; i < 8; i++) begin
      w = b2b_words[i / 4];
      send_byte(w[8*(i % 4) +: 8], 0);
      if (i % 4 == 3) b2b_cyc[i / 4] = byte_cyc;
    end
    repeat (5) @(negedge clk);
    send_word(MARKER, 0);
    repeat (4) @(negedge clk);
    check("b2b_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("b2b_addr%0d", i), wr_addr[i], 32'(i));
        check($sformatf("b2b_data%0d", i), wr_data[i], b2b_words[i]);
        check($sformatf("b2b_latency%0d", i), 32'(wr_cyc[i]), 32'(b2b_cyc[i] + 2));
      end
    end
    check("b2b_done", 32'(done), 32'd1);

    // Overflow: five data words into a four-word memory.
    restart();
    for (int i = 0; i < 5; i++) send_word(32'h1000_0000 + 32'(i), 2);
    repeat (4) @(negedge clk);
    check("ovf_nwrites", 32'(wr_addr.size()), 32'd4);
    if (wr_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("ovf_addr%0d", i), wr_addr[i], 32'(i));
        check($sformatf("ovf_data%0d", i), wr_data[i], 32'h1000_0000 + 32'(i));
      end
    end
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_done", 32'(done), 32'd1);
    check("ovf_cnt", 32'(word_cnt), 32'd4);

    // Exactly MEM_WORDS words then the marker: no overflow.
    restart();
    check("full_ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) send_word(32'h2000_0000 + 32'(i), 1);
    send_word(MARKER, 1);
    repeat (4) @(negedge clk);
    check("full_nwrites", 32'(wr_addr.size()), 32'd4);
    check("full_ovf", 32'(overflow), 32'd0);
    check("full_cnt", 32'(word_cnt), 32'd4);
    check("full_done", 32'(done), 32'd1);

    // Timeout: a stalled partial word is discarded after TIMEOUT_CYC cycles.
    restart();
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    check("tmo_before_edge", 32'(frame_err), 32'd0);
    @(negedge clk);
    check("tmo_at_edge", 32'(frame_err), 32'd1);
    send_word(32'h4433_2211, 0);
    repeat (3) @(negedge clk);
    send_word(MARKER, 0);
    repeat (4) @(negedge clk);
    check("tmo_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("tmo_addr", wr_addr[0], 32'd0);
      check("tmo_data", wr_data[0], 32'h4433_2211);
    end
    check("tmo_ferr_sticky", 32'(frame_err), 32'd1);
    check("tmo_done", 32'(done), 32'd1);

    // Abort after two bytes, then reload from IDLE.
    restart();
    check("abort_ferr_cleared", 32'(frame_err), 32'd0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    load_en = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_core_rst", 32'(core_rst), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_nwrites", 32'(wr_addr.size()), 32'd0);
    load_en = 1'b1;
    repeat (2) @(negedge clk);
    send_word(32'hCAFE_F00D, 0);
    repeat (2) @(negedge clk);
    send_word(MARKER, 0);
    repeat (4) @(negedge clk);
    check("reload_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("reload_addr", wr_addr[0], 32'd0);
      check("reload_data", wr_data[0], 32'hCAFE_F00D);
    end
    check("reload_done", 32'(done), 32'd1);
    load_en = 1'b0;
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    clear_log();
    check("pulse_core_rst", 32'(core_rst), 32'd1);
    check("pulse_cnt", 32'(word_cnt), 32'd0);
    send_word(32'h0BAD_C0DE, 0);
    repeat (2) @(negedge clk);
    send_word(MARKER, 0);
    repeat (4) @(negedge clk);
    check("pulse_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("pulse_addr", wr_addr[0], 32'd0);
      check("pulse_data", wr_data[0], 32'h0BAD_C0DE);
    end

    // Async reset in the middle of a WRITE.
    restart();
    send_word(32'h1111_1111, 0);
    repeat (3) @(negedge clk);
    send_byte(8'hAA, 0);
    repeat (TIMEOUT_CYC + 2) @(negedge clk);
    check("arst_pre_ferr", 32'(frame_err), 32'd1);
    check("arst_pre_cnt", 32'(word_cnt), 32'd1);
    send_word(32'h2222_2222, 0);
    seen_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_we === 1'b1) begin
        seen_we = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("arst_we_seen", 32'(seen_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_we", 32'(imem_we), 32'd0);
    check("arst_core_rst", 32'(core_rst), 32'd1);
    check("arst_done", 32'(done), 32'd0);
    check("arst_cnt", 32'(word_cnt), 32'd0);
    check("arst_flags", {30'd0, overflow, frame_err}, 32'd0);
    check("arst_addr", 32'(imem_addr), 32'd0);
    check("arst_wdata", imem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
